// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button conditioner: sync, polarity, debounce, edge pulses, sticky press flags
// Each channel is independent; a new synchronised level is accepted after DB_CYCLES stable cycles.

module button_debounce #(
  parameter int WIDTH      = 2,
  parameter int DB_CYCLES  = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_btn_raw,
  input  logic [WIDTH-1:0] i_ev_clr,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_event
);

  localparam int            CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] w_norm;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;

  logic [WIDTH-1:0] r_s0;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_event;

  // pressed reads as 1 after normalisation
  assign w_norm = i_btn_raw ^ {WIDTH{ACTIVE_LOW}};

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [CW-1:0] r_cnt;

    assign w_accept[g] = (r_s1[g] != r_level[g]) && (r_cnt == CNT_MAX);

    // any agreement with the current level restarts the stability count
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_cnt <= '0;
      end else if (r_s1[g] == r_level[g]) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign w_rise_next = w_accept & r_s1;
  assign w_fall_next = w_accept & ~r_s1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s0    <= '0;
      r_s1    <= '0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_event <= '0;
    end else begin
      r_s0    <= w_norm;
      r_s1    <= r_s0;
      r_level <= r_level ^ w_accept;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
      // a new press wins over a clear arriving on the same edge
      r_event <= w_rise_next | (r_event & ~i_ev_clr);
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_event = r_event;

endmodule
